// File: rtl/adf4351_pkg.sv
// ADF4351 synthesizer calculator: shared types, register constants and band limits.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package adf4351_pkg;

    // Controller sequence: capture, range check, integer divide, fractional divide, pack.
    typedef enum logic [2:0] {
        IDLE,
        PREP,
        DIV_INT,
        DIV_FRAC,
        PACK
    } state_t;

    // Register 4 with RF divider select field (bits 22:20) cleared.
    localparam logic [31:0] R4_BASE = 32'h008C803C;

    // Power-up register images.
    localparam logic [31:0] R0_RST  = 32'h00501F40;
    localparam logic [31:0] R4_RST  = 32'h00AC803C;

    // Output band and VCO band limits in kHz.
    localparam int BAND_MIN_KHZ = 34375;
    localparam int VCO_MIN_KHZ  = 2200000;
    localparam int BAND_MAX_KHZ = 4400000;

    // Legal range of the 16-bit integer divider word.
    localparam int INT_MIN = 23;
    localparam int INT_MAX = 65535;

    // Register 0 layout: reserved, INT, FRAC, control bits 000.
    function automatic logic [31:0] pack_r0(input logic [15:0] int_val, input logic [11:0] frac_val);
        return {1'b0, int_val, frac_val, 3'b000};
    endfunction

    // Register 4 with the RF output divider exponent merged in.
    function automatic logic [31:0] pack_r4(input logic [2:0] k);
        return R4_BASE | (32'(k) << 20);
    endfunction

endpackage

// File: rtl/adf4351_synth_calc_if.sv
// Request/result bundle between a host and the ADF4351 register calculator.
// Latency: n/a (wiring only).
// Backpressure: none; the host watches o_busy/o_done, requests while busy are dropped.
interface adf4351_synth_calc_if #(
    parameter int FREQ_W = 24
);
    logic              i_start;
    logic              i_lo_set;
    logic [FREQ_W-1:0] i_freq;
    logic [31:0]       o_adf_r0;
    logic [31:0]       o_adf_r4;
    logic              o_busy;
    logic              o_done;
    logic              o_err;

    modport master (
        output i_start, i_lo_set, i_freq,
        input  o_adf_r0, o_adf_r4, o_busy, o_done, o_err
    );

    modport slave (
        input  i_start, i_lo_set, i_freq,
        output o_adf_r0, o_adf_r4, o_busy, o_done, o_err
    );
endinterface

// File: rtl/seq_udiv.sv
// 32-bit unsigned restoring divider, one quotient bit per clock.
// Latency: first bit on the i_start edge, o_done high in the cycle after the 32nd bit.
// Backpressure: none; a new i_start restarts the division, results hold until then.
module seq_udiv (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    output logic [31:0] o_quotient,
    output logic [31:0] o_remainder,
    output logic        o_done
);
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_dvs;
    logic [4:0]  r_cnt;
    logic        r_done;

    logic [31:0] w_src_rem;
    logic [31:0] w_src_quo;
    logic [31:0] w_src_dvs;
    logic [32:0] w_trial;
    logic        w_ge;
    logic [31:0] w_diff;
    logic [31:0] w_rem_nxt;
    logic [31:0] w_quo_nxt;

    // One restoring step; on i_start it runs on the fresh operands so the load cycle counts as bit 31.
    always_comb begin
        w_src_rem = i_start ? 32'd0      : r_rem;
        w_src_quo = i_start ? i_dividend : r_quo;
        w_src_dvs = i_start ? i_divisor  : r_dvs;
        w_trial   = {w_src_rem, w_src_quo[31]};
        w_ge      = (w_trial >= {1'b0, w_src_dvs});
        // When w_ge holds the true difference is below the divisor, so 32 bits are exact.
        w_diff    = w_trial[31:0] - w_src_dvs;
        w_rem_nxt = w_ge ? w_diff : w_trial[31:0];
        w_quo_nxt = {w_src_quo[30:0], w_ge};
    end

    // Step register: load-and-step on start, then 31 further steps counted down.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_dvs  <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_rem <= w_rem_nxt;
                r_quo <= w_quo_nxt;
                r_dvs <= i_divisor;
                r_cnt <= 5'd31;
            end else if (r_cnt != 5'd0) begin
                r_rem <= w_rem_nxt;
                r_quo <= w_quo_nxt;
                r_cnt <= r_cnt - 5'd1;
                if (r_cnt == 5'd1) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;
    assign o_done      = r_done;
endmodule

// File: rtl/adf4351_synth_calc.sv
// ADF4351 R0/R4 calculator from a kHz target; ADF4351_CALC_ROUND_EN selects FRAC rounding.
// Latency: o_done 66 cycles after the accepting edge, 2 cycles on an out-of-band request.
// Backpressure: i_start is dropped (never queued) while busy and in the o_done cycle.
module adf4351_synth_calc
    import adf4351_pkg::*;
#(
    parameter int FREQ_W  = 24,
    parameter int PFD_KHZ = 25000,
    parameter int MOD_VAL = 1000,
    parameter int IF_KHZ  = 2000
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    adf4351_synth_calc_if.slave  s_if
);
    localparam logic [FREQ_W-1:0]      IF_U     = FREQ_W'(IF_KHZ);
    localparam logic signed [FREQ_W:0] IF_S     = (FREQ_W+1)'(IF_KHZ);
    localparam logic [31:0]            PFD_W    = 32'(PFD_KHZ);
    localparam logic [31:0]            MOD_W    = 32'(MOD_VAL);
`ifdef ADF4351_CALC_ROUND_EN
    localparam logic [31:0]            HALF_PFD = 32'(PFD_KHZ / 2);
`endif

    state_t r_state;
    state_t w_state_nxt;

    logic signed [FREQ_W:0] r_f;
    logic                   r_lo_under;
    logic                   r_perr;
    logic [2:0]             r_k;
    logic [31:0]            r_int;
    logic [31:0]            r_r0;
    logic [31:0]            r_r4;
    logic                   r_done;
    logic                   r_err;

    logic                   w_accept;
    logic signed [FREQ_W:0] w_freq_s;
    logic signed [31:0]     w_f_ext;
    logic                   w_prep_err;
    logic [2:0]             w_k;
    logic [31:0]            w_vco;
    logic                   w_div_start;
    logic [31:0]            w_div_dvd;
    logic [31:0]            w_div_quo;
    logic [31:0]            w_div_rem;
    logic                   w_div_done;
    logic [31:0]            w_frac_dvd;
    logic [31:0]            w_int_fin;
    logic [11:0]            w_frac_fin;
    logic                   w_pack_err;

    // The DONE cycle is already IDLE but must not accept a new request.
    assign w_accept = (r_state == IDLE) && s_if.i_start && !r_done;
    assign w_freq_s = $signed({1'b0, s_if.i_freq});

    // Band check on the signed effective frequency; a negative LO result fails the lower bound too.
    assign w_f_ext    = 32'(r_f);
    assign w_prep_err = r_lo_under || (w_f_ext < BAND_MIN_KHZ) || (w_f_ext > BAND_MAX_KHZ);

    // Smallest RF divider exponent that lifts F into the VCO band (6 always suffices in band).
    always_comb begin
        w_k = 3'd6;
        for (int i = 6; i >= 0; i--) begin
            if ((32'(r_f[FREQ_W-1:0]) << i) >= 32'(VCO_MIN_KHZ)) begin
                w_k = 3'(i);
            end
        end
    end

    assign w_vco = 32'(r_f[FREQ_W-1:0]) << w_k;

    // Second division operand: remainder of the integer division scaled by the modulus.
`ifdef ADF4351_CALC_ROUND_EN
    assign w_frac_dvd = w_div_rem * MOD_W + HALF_PFD;
`else
    assign w_frac_dvd = w_div_rem * MOD_W;
`endif

    // Final INT/FRAC; a rounded FRAC equal to the modulus carries into INT before the range check.
`ifdef ADF4351_CALC_ROUND_EN
    always_comb begin
        w_int_fin  = r_int;
        w_frac_fin = w_div_quo[11:0];
        if (w_div_quo == MOD_W) begin
            w_int_fin  = r_int + 32'd1;
            w_frac_fin = 12'd0;
        end
    end
`else
    assign w_int_fin  = r_int;
    assign w_frac_fin = w_div_quo[11:0];
`endif

    assign w_pack_err = r_perr || (w_int_fin < INT_MIN) || (w_int_fin > INT_MAX);

    // Single divider shared by the integer and fractional divisions.
    seq_udiv u_div (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start     (w_div_start),
        .i_dividend  (w_div_dvd),
        .i_divisor   (PFD_W),
        .o_quotient  (w_div_quo),
        .o_remainder (w_div_rem),
        .o_done      (w_div_done)
    );

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and divider launch; each division is kicked off on the edge leaving the prior state.
    always_comb begin
        w_state_nxt = r_state;
        w_div_start = 1'b0;
        w_div_dvd   = '0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = PREP;
                end
            end
            PREP: begin
                if (w_prep_err) begin
                    w_state_nxt = PACK;
                end else begin
                    w_div_start = 1'b1;
                    w_div_dvd   = w_vco;
                    w_state_nxt = DIV_INT;
                end
            end
            DIV_INT: begin
                if (w_div_done) begin
                    w_div_start = 1'b1;
                    w_div_dvd   = w_frac_dvd;
                    w_state_nxt = DIV_FRAC;
                end
            end
            DIV_FRAC: begin
                if (w_div_done) begin
                    w_state_nxt = PACK;
                end
            end
            PACK: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: capture request, remember PREP verdict and k, hold INT, publish registers in PACK.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_f        <= '0;
            r_lo_under <= 1'b0;
            r_perr     <= 1'b0;
            r_k        <= '0;
            r_int      <= '0;
            r_r0       <= R0_RST;
            r_r4       <= R4_RST;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (w_accept) begin
                r_f        <= s_if.i_lo_set ? (w_freq_s - IF_S) : w_freq_s;
                r_lo_under <= s_if.i_lo_set && (s_if.i_freq < IF_U);
            end
            if (r_state == PREP) begin
                r_perr <= w_prep_err;
                r_k    <= w_k;
            end
            if ((r_state == DIV_INT) && w_div_done) begin
                r_int <= w_div_quo;
            end
            if (r_state == PACK) begin
                r_done <= 1'b1;
                r_err  <= w_pack_err;
                if (!w_pack_err) begin
                    r_r0 <= pack_r0(w_int_fin[15:0], w_frac_fin);
                    r_r4 <= pack_r4(r_k);
                end
            end
        end
    end

    assign s_if.o_adf_r0 = r_r0;
    assign s_if.o_adf_r4 = r_r4;
    assign s_if.o_busy   = (r_state != IDLE);
    assign s_if.o_done   = r_done;
    assign s_if.o_err    = r_err;
endmodule

// File: doc/adf4351_synth_calc.md
ADF4351_SYNTH_CALC -- requirements
Module: adf4351_synth_calc

Interface
REQ-001 SHALL have parameter FREQ_W, default 24, width of the kHz frequency input.
REQ-002 SHALL have parameter PFD_KHZ, default 25000, PFD frequency in kHz; legal range 1000..100000.
REQ-003 SHALL have parameter MOD_VAL, default 1000, fractional modulus; legal range 2..4095.
REQ-004 SHALL have parameter IF_KHZ, default 2000, LO offset subtracted when LO_SET=1.
REQ-005 SHALL have one clock and one reset: asynchronous, active-high.
REQ-006 CLK  input  1  rising-edge clock.
REQ-007 RST  input  1  asynchronous active-high reset.
REQ-008 START  input  1  one-cycle request; sampled only in IDLE.
REQ-009 LO_SET  input  1  1 = effective frequency is FREQ-IF_KHZ; sampled with START.
REQ-010 FREQ  input  FREQ_W  target frequency in kHz; sampled with START.
REQ-011 ADF_R0  output  32  ADF4351 register 0 word.
REQ-012 ADF_R4  output  32  ADF4351 register 4 word.
REQ-013 BUSY  output  1  high from the cycle after START acceptance until DONE.
REQ-014 DONE  output  1  one-cycle completion pulse.
REQ-015 ERR  output  1  one-cycle pulse coincident with DONE on range failure.

Function
REQ-016 SHALL use FSM states IDLE, PREP, DIV_INT, DIV_FRAC and PACK; the default branch SHALL return to IDLE.
REQ-017 IDLE+START SHALL register the effective frequency F (FREQ or FREQ-IF_KHZ, FREQ_W+1-bit signed) and go to PREP.
REQ-018 PREP SHALL flag an error when F<34375 or F>4400000, or when FREQ<IF_KHZ with LO_SET=1; on error it SHALL go to PACK.
REQ-019 Otherwise PREP SHALL pick the smallest k in 0..6 with F*2^k>=2200000, set VCO=F<<k (32-bit), and go to DIV_INT.
REQ-020 DIV_INT SHALL compute INT=VCO/PFD_KHZ and REM=VCO%PFD_KHZ by restoring division, 1 bit/cycle, exactly 32 cycles.
REQ-021 DIV_FRAC SHALL compute FRAC=(REM*MOD_VAL)/PFD_KHZ, 32-bit dividend, 32 cycles.
REQ-022 PACK SHALL reject INT<23 or INT>65535 as an error.
REQ-023 PACK without error SHALL load ADF_R0={1'b0, INT[15:0], FRAC[11:0], 3'b000} and ADF_R4=32'h008C803C|(k<<20).
REQ-024 PACK SHALL pulse DONE and ERR (ERR only on error), return to IDLE, and leave ADF_R0/ADF_R4 unchanged on error.
REQ-025 Latency SHALL be: DONE high 66 cycles after the START sampling edge on success, and 2 cycles after it on a PREP error.
REQ-026 START while BUSY SHALL be ignored, and SHALL NOT be queued.
REQ-027 The DONE cycle SHALL be IDLE-equivalent for output use; a START arriving in the cycle DONE is high SHALL be ignored.

Reset
REQ-028 RST SHALL force IDLE, BUSY=0, DONE=0, ERR=0, ADF_R0=32'h00501F40 and ADF_R4=32'h00AC803C, at any point including mid-division.

Configuration
REQ-029 With ADF4351_CALC_ROUND_EN defined, DIV_FRAC SHALL use dividend REM*MOD_VAL+PFD_KHZ/2 (round to nearest).
REQ-030 Under rounding, FRAC==MOD_VAL SHALL become FRAC=0 with INT+1, and REQ-022 SHALL be checked after that carry.
REQ-031 Without ADF4351_CALC_ROUND_EN, FRAC SHALL be truncated, and the carry logic SHALL be absent.

Structure
REQ-032 Package adf4351_pkg SHALL hold the FSM state enum, R4 base constant 32'h008C803C, the reset constants for R0 and R4, band limits 34375/2200000/4400000, and INT_MIN=23.
REQ-033 Sub-module seq_udiv (32-bit, start/done, 32-cycle restoring divider) SHALL be instantiated once and reused for both divisions.

Verification (PFD_KHZ=25000, MOD_VAL=1000, IF_KHZ=2000)
REQ-034 FREQ=100000, LO_SET=0 -> after 66 cycles: DONE, ERR=0, R0=32'h00400000, R4=32'h00DC803C.
REQ-035 FREQ=1000000, LO_SET=1 -> R0=32'h004F9540 (INT 159, FRAC 680), R4=32'h00AC803C.
REQ-036 FREQ=2200013 -> R0=32'h002C0000 truncated, 32'h002C0008 rounded; FREQ=2224990 -> 32'h002C1F38 truncated, 32'h002C8000 rounded (carry).
REQ-037 FREQ=30000 -> DONE and ERR 2 cycles later; R0/R4 keep their prior values.
REQ-038 Second START at cycle 10 of a conversion -> ignored, with single DONE at cycle 66.
REQ-039 RST at cycle 40 -> reset values immediately, BUSY=0, and no DONE.
